// File: rtl/niosdramproc_mult_pipe.sv
// Three-stage pipelined integer multiplier built from half-width partial products, with stall and flush.
// Define NIOSDRAMPROC_MULT_HI_EN to enable the high-word ops (MULXSS/MULXSU/MULXUU); otherwise every op returns the low word.
module niosdramproc_mult_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [1:0]        op,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] result
);
  localparam int HALF_W = DATA_W / 2;

  logic valid_s1;
  logic valid_s2;
  logic advance;

  assign advance = !stall;

  // Flush beats stall and also drops an in_valid arriving in the same cycle.
  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_s1  <= 1'b0;
      valid_s2  <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      valid_s1  <= 1'b0;
      valid_s2  <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      valid_s1  <= in_valid;
      valid_s2  <= valid_s1;
      out_valid <= valid_s2;
    end
  end

`ifdef NIOSDRAMPROC_MULT_HI_EN
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXSS = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXUU = 2'b11
  } op_e;

  localparam int PP_W   = 2 * HALF_W + 2;
  localparam int PROD_W = 2 * DATA_W;

  op_e                      op_s1;
  op_e                      op_s2;
  logic signed [HALF_W:0]   a_lo_s1, a_hi_s1, b_lo_s1, b_hi_s1;
  logic signed [PP_W-1:0]   pp_ll, pp_hl, pp_lh, pp_hh;
  logic signed [PROD_W-1:0] ll_x, hl_x, lh_x, hh_x;
  logic [PROD_W-1:0]        prod;
  logic                     src1_signed;
  logic                     src2_signed;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    src1_signed = (op == OP_MULXSS) || (op == OP_MULXSU);
    src2_signed = (op == OP_MULXSS);
  end

  // Low halves are always unsigned; the top half carries the operand's sign when the mode asks for it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_s1   <= OP_MUL;
      a_lo_s1 <= '0;
      a_hi_s1 <= '0;
      b_lo_s1 <= '0;
      b_hi_s1 <= '0;
    end else if (advance) begin
      op_s1   <= op_e'(op);
      a_lo_s1 <= {1'b0, src1[HALF_W-1:0]};
      a_hi_s1 <= {src1_signed & src1[DATA_W-1], src1[DATA_W-1:HALF_W]};
      b_lo_s1 <= {1'b0, src2[HALF_W-1:0]};
      b_hi_s1 <= {src2_signed & src2[DATA_W-1], src2[DATA_W-1:HALF_W]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_s2 <= OP_MUL;
      pp_ll <= '0;
      pp_hl <= '0;
      pp_lh <= '0;
      pp_hh <= '0;
    end else if (advance) begin
      op_s2 <= op_s1;
      pp_ll <= PP_W'(a_lo_s1) * PP_W'(b_lo_s1);
      pp_hl <= PP_W'(a_hi_s1) * PP_W'(b_lo_s1);
      pp_lh <= PP_W'(a_lo_s1) * PP_W'(b_hi_s1);
      pp_hh <= PP_W'(a_hi_s1) * PP_W'(b_hi_s1);
    end
  end

  // Sign-extend each partial product to the full width; the sum wraps modulo 2^PROD_W.
  always_comb begin
    ll_x = PROD_W'(pp_ll);
    hl_x = PROD_W'(pp_hl);
    lh_x = PROD_W'(pp_lh);
    hh_x = PROD_W'(pp_hh);
    prod = ll_x + ((hl_x + lh_x) <<< HALF_W) + (hh_x <<< DATA_W);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
    end else if (advance) begin
      result <= (op_s2 == OP_MUL) ? prod[DATA_W-1:0] : prod[PROD_W-1:DATA_W];
    end
  end

`else
  logic [HALF_W-1:0] a_lo_s1, a_hi_s1, b_lo_s1, b_hi_s1;
  logic [DATA_W-1:0] pp_ll;
  logic [HALF_W-1:0] pp_hl, pp_lh;
  logic [HALF_W-1:0] cross_sum;
  logic              unused_op;

  // Only the low word is produced, so the op code has no effect in this build.
  assign unused_op = ^op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_lo_s1 <= '0;
      a_hi_s1 <= '0;
      b_lo_s1 <= '0;
      b_hi_s1 <= '0;
    end else if (advance) begin
      a_lo_s1 <= src1[HALF_W-1:0];
      a_hi_s1 <= src1[DATA_W-1:HALF_W];
      b_lo_s1 <= src2[HALF_W-1:0];
      b_hi_s1 <= src2[DATA_W-1:HALF_W];
    end
  end

  // Cross products only reach the low word through their bottom HALF_W bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pp_ll <= '0;
      pp_hl <= '0;
      pp_lh <= '0;
    end else if (advance) begin
      pp_ll <= DATA_W'(a_lo_s1) * DATA_W'(b_lo_s1);
      pp_hl <= a_hi_s1 * b_lo_s1;
      pp_lh <= a_lo_s1 * b_hi_s1;
    end
  end

  assign cross_sum = pp_hl + pp_lh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
    end else if (advance) begin
      result <= pp_ll + {cross_sum, {HALF_W{1'b0}}};
    end
  end
`endif

endmodule

// File: tb/tb_niosdramproc_mult_pipe.sv
// Randomized self-checking bench for niosdramproc_mult_pipe at DATA_W = 16, 32 and 64 in parallel.
// Expected results come from a full-width arithmetic model and a three-slot latency model with stall/flush.
module tb_niosdramproc_mult_pipe;
`ifdef NIOSDRAMPROC_MULT_HI_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        in_valid = 1'b0;
  logic        stall    = 1'b0;
  logic        flush    = 1'b0;
  logic [1:0]  op       = 2'b00;
  logic [63:0] src1     = '0;
  logic [63:0] src2     = '0;

  logic        ov16, ov32, ov64;
  logic [15:0] r16;
  logic [31:0] r32;
  logic [63:0] r64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          v;
    logic [63:0] e16;
    logic [63:0] e32;
    logic [63:0] e64;
  } slot_t;

  slot_t pipe [3];

  always #5 clk = ~clk;

  niosdramproc_mult_pipe #(.DATA_W(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .src1(src1[15:0]), .src2(src2[15:0]), .op(op),
    .stall(stall), .flush(flush), .out_valid(ov16), .result(r16)
  );

  niosdramproc_mult_pipe #(.DATA_W(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .src1(src1[31:0]), .src2(src2[31:0]), .op(op),
    .stall(stall), .flush(flush), .out_valid(ov32), .result(r32)
  );

  niosdramproc_mult_pipe #(.DATA_W(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .src1(src1), .src2(src2), .op(op),
    .stall(stall), .flush(flush), .out_valid(ov64), .result(r64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Full product of w-bit operands with per-op signedness, then word selection.
  function automatic logic [63:0] ref_result(input int w, input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] o);
    logic [63:0]         mask, am, bm;
    logic signed [129:0] xa, xb, p;
    logic [129:0]        hi_part;
    bit                  sa, sb, want_hi;
    mask    = (64'd1 << w) - 64'd1;
    am      = a & mask;
    bm      = b & mask;
    want_hi = HI_EN && (o != 2'b00);
    sa      = HI_EN && (o == 2'b01 || o == 2'b10);
    sb      = HI_EN && (o == 2'b01);
    xa      = {66'd0, am};
    xb      = {66'd0, bm};
    if (sa && am[w-1]) xa = xa - (130'sd1 <<< w);
    if (sb && bm[w-1]) xb = xb - (130'sd1 <<< w);
    p       = xa * xb;
    hi_part = p >> w;
    return want_hi ? (hi_part[63:0] & mask) : (p[63:0] & mask);
  endfunction

  task automatic check_outputs();
    check("out_valid16", 64'(ov16), 64'(pipe[2].v));
    check("out_valid32", 64'(ov32), 64'(pipe[2].v));
    check("out_valid64", 64'(ov64), 64'(pipe[2].v));
    if (pipe[2].v) begin
      check("result16", 64'(r16), pipe[2].e16);
      check("result32", 64'(r32), pipe[2].e32);
      check("result64", r64, pipe[2].e64);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
  task automatic cycle(input bit iv, input logic [63:0] a, input logic [63:0] b, input logic [1:0] o,
                       input bit st, input bit fl);
    in_valid = iv;
    src1     = a;
    src2     = b;
    op       = o;
    stall    = st;
    flush    = fl;
    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
    end else if (!st) begin
      pipe[2]     = pipe[1];
      pipe[1]     = pipe[0];
      pipe[0].v   = iv;
      pipe[0].e16 = ref_result(16, a, b, o);
      pipe[0].e32 = ref_result(32, a, b, o);
      pipe[0].e64 = ref_result(64, a, b, o);
    end
    #1;
    check_outputs();
  endtask

  task automatic bubble();
    cycle(1'b0, 64'd0, 64'd0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic expect32(input string tag, input logic [31:0] exp);
    check({tag, "_valid"}, 64'(ov32), 64'd1);
    check(tag, 64'(r32), 64'(exp));
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_8000_8000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB  = 64'h0000_0000_8000_0000;

  initial begin
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, e16: '0, e32: '0, e64: '0};

    #1;
    check("reset_out_valid", 64'(ov32), 64'd0);
    check("reset_result", 64'(r32), 64'd0);
    #1 reset_n = 1'b1;

    // All-ones operands, four op codes back to back
    cycle(1'b1, ALL1, ALL1, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, ALL1, ALL1, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, ALL1, ALL1, 2'b01, 1'b0, 1'b0);
    expect32("ff_mul", 32'h0000_0001);
    cycle(1'b1, ALL1, ALL1, 2'b10, 1'b0, 1'b0);
    expect32("ff_mulxuu", HI_EN ? 32'hFFFF_FFFE : 32'h0000_0001);
    bubble();
    expect32("ff_mulxss", HI_EN ? 32'h0000_0000 : 32'h0000_0001);
    bubble();
    expect32("ff_mulxsu", HI_EN ? 32'hFFFF_FFFF : 32'h0000_0001);
    bubble();

    // Most-negative operands
    cycle(1'b1, MSB, MSB, 2'b01, 1'b0, 1'b0);
    cycle(1'b1, MSB, MSB, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, MSB, MSB, 2'b10, 1'b0, 1'b0);
    expect32("msb_mulxss", HI_EN ? 32'h4000_0000 : 32'h0000_0000);
    bubble();
    expect32("msb_mulxuu", HI_EN ? 32'h4000_0000 : 32'h0000_0000);
    bubble();
    expect32("msb_mulxsu", HI_EN ? 32'hC000_0000 : 32'h0000_0000);
    bubble();

    // Stall for two cycles after issue, then stall again while the result is presented
    cycle(1'b1, 64'h0001_2345, 64'h0001_0000, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 64'd0, 64'd0, 2'b00, 1'b1, 1'b0);
    cycle(1'b1, 64'd7, 64'd7, 2'b00, 1'b1, 1'b0);
    bubble();
    bubble();
    expect32("stall_result", 32'h2345_0000);
    cycle(1'b1, 64'd9, 64'd9, 2'b00, 1'b1, 1'b0);
    expect32("stall_hold1", 32'h2345_0000);
    cycle(1'b0, 64'd0, 64'd0, 2'b00, 1'b1, 1'b0);
    expect32("stall_hold2", 32'h2345_0000);
    bubble();
    bubble();

    // Flush with three in flight plus a fourth issued in the same cycle
    cycle(1'b1, 64'd11, 64'd13, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 64'd17, 64'd19, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, 64'd23, 64'd29, 2'b01, 1'b0, 1'b0);
    cycle(1'b1, 64'd31, 64'd37, 2'b00, 1'b0, 1'b1);
    check("flush_kill", 64'(ov32), 64'd0);
    for (int i = 0; i < 3; i++) begin
      bubble();
      check("flush_no_valid", 64'(ov32), 64'd0);
    end
    cycle(1'b1, 64'd3, 64'd5, 2'b00, 1'b0, 1'b0);
    bubble();
    bubble();
    expect32("after_flush", 32'd15);
    bubble();

    // Asynchronous reset mid-pipeline
    cycle(1'b1, 64'd41, 64'd43, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 64'd47, 64'd53, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 64'd59, 64'd61, 2'b00, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_out_valid16", 64'(ov16), 64'd0);
    check("rst_out_valid32", 64'(ov32), 64'd0);
    check("rst_out_valid64", 64'(ov64), 64'd0);
    check("rst_result16", 64'(r16), 64'd0);
    check("rst_result32", 64'(r32), 64'd0);
    check("rst_result64", r64, 64'd0);
    for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bubble();
      check("rst_no_emerge", 64'(ov32), 64'd0);
    end

    // Random traffic with occasional stall and flush
    for (int n = 0; n < 10000; n++) begin
      cycle($urandom_range(0, 9) != 0, pick_operand(), pick_operand(), 2'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < 3; i++) bubble();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/niosdramproc_mult_pipe.md
# niosdramproc_mult_pipe

Parametrised, pipelined integer multiplier for the Nios-class processor in the niosdramproc system, next generation after the fixed 32-bit low-word multiply cell. It splits operands into half-width partial products, sums them over a fixed 3-stage pipeline, and returns either the low or the high product word. Signed and unsigned high-word modes are supported. It adds valid tracking, pipeline stall and flush, and sits between the CPU's execute/memory stages and the writeback mux.

## Interface
- DATA_W, 32, operand and result width; even, 16..64
- HALF_W, DATA_W/2, partial-product operand width (derived, not overridable)
- clk  in  1  rising-edge clock, single clock domain
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands and op presented this cycle
- src1  in  DATA_W  multiplicand
- src2  in  DATA_W  multiplier
- op  in  2  00 MUL low word, 01 MULXSS high signed×signed, 10 MULXSU high signed×unsigned, 11 MULXUU high unsigned×unsigned
- stall  in  1  freeze all pipeline stages
- flush  in  1  synchronous kill of all in-flight operations
- out_valid  out  1  result valid
- result  out  DATA_W  selected product word

## Operation
- S1 captures src1, src2, op and in_valid.
  - Operands are extended to HALF_W+1-bit halves.
  - The top half is sign-extended when the mode treats that operand as signed: src1 for 01/10, src2 for 01 only.
  - Otherwise the top half is zero-extended.
- S2 registers the four partial products: lo×lo, hi1×lo2, lo1×hi2, hi×hi, each signed (HALF_W+1)×(HALF_W+1).
- S3 forms the 2·DATA_W-bit sum and registers the word selected by op into result, with out_valid.
  - Sum: pp_ll + (pp_hl + pp_lh) << HALF_W + pp_hh << DATA_W, computed modulo 2^(2·DATA_W).
  - op 00 selects bits [DATA_W-1:0]; any other op selects [2·DATA_W-1:DATA_W].
- The low word is identical for all signedness combinations.
- The op code travels with its data through every stage.
- Bubbles (in_valid=0) propagate as out_valid=0.
  - The result register still updates each unstalled cycle, so its value is don't-care when out_valid=0.
- Stall: every stage register, including out_valid and result, holds its value. in_valid presented during a stall is ignored; the CPU must hold it.
- Flush: clears the S1/S2/S3 valid bits on the next edge. Data registers may load freely.
  - Flush has priority over stall.
  - in_valid in the same cycle as flush is dropped.
- Reset: all valid bits, result and stage registers go to 0 asynchronously. An operation in flight is lost; out_valid=0 the cycle after reset deasserts.

## Timing
- Latency is 3 cycles: in_valid at edge N gives out_valid/result after edge N+3 when no stall occurs.
- Each stall cycle adds one cycle.
- Throughput is 1 operation/cycle when unstalled. Back-to-back operations with mixed op codes are legal.
- There are no combinational paths from inputs to outputs.
- Reset values: out_valid=0, result=0.

## Configuration
- NIOSDRAMPROC_MULT_HI_EN defined: all four op codes are supported as above.
- Macro undefined:
  - op is ignored and every operation returns the low word (MUL).
  - pp_hh and the upper halves of pp_hl/pp_lh are not generated.
  - Cross products are truncated to HALF_W bits before the add.
  - Latency and handshake are unchanged.

## Test plan
- DATA_W=32, src1=src2=0xFFFFFFFF, op=00/11/01/10 back-to-back → results 0x00000001, 0xFFFFFFFE, 0x00000000, 0xFFFFFFFF on 4 consecutive cycles starting 3 cycles after the first in_valid.
- src1=0x80000000, src2=0x80000000, op=01 → 0x40000000; op=11 → 0x40000000; op=10 → 0xC0000000.
- src1=0x00012345, src2=0x00010000, op=00, stall held 2 cycles after issue → result 0x23450000, out_valid asserted at cycle 5 and held while stall=1.
- Issue 3 operations, assert flush with a 4th in_valid in the same cycle → no out_valid for any of the 4. A 5th operation issued afterwards returns normally.
- reset_n pulsed low mid-pipeline with 2 operations in flight → out_valid=0 and result=0 immediately; neither operation emerges.
- Macro undefined: 0xFFFFFFFF×0xFFFFFFFF with op=11 → 0x00000001, latency 3. Random 10k operations checked against a reference model for DATA_W=16, 32 and 64.
